cp0_ctrl: RTL and testbench

CP0_CTRL -- requirements
Module: cp0_ctrl

---
 rtl/cp0_ctrl.sv | 154 +++++++++++++++
 tb/tb_cp0_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_ctrl.sv
// MIPS-style coprocessor 0: Status/Cause/EPC/BadVAddr/Count/Compare registers,
// timer interrupt, exception entry and ERET redirect generation.
module cp0_ctrl #(
  parameter int          HW_INT     = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] PRID_VAL   = 32'h0000_4220,
  parameter logic [31:0] CONFIG_VAL = 32'h8000_0000,
  parameter logic [31:0] EXC_VEC    = 32'hBFC0_0380
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HW_INT-1:0] int_i,
  input  logic              we_i,
  input  logic [4:0]        waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [4:0]        raddr_i,
  output logic [31:0]       rdata_o,
  input  logic              exc_valid_i,
  input  logic [4:0]        exc_code_i,
  input  logic [31:0]       exc_pc_i,
  input  logic              exc_bd_i,
  input  logic [31:0]       exc_badva_i,
  input  logic              eret_i,
  output logic              int_req_o,
  output logic [31:0]       epc_o,
  output logic [31:0]       status_o,
  output logic [31:0]       cause_o,
  output logic              flush_o,
  output logic [31:0]       flush_pc_o
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  logic [31:0] count_q, compare_q, epc_q, badva_q;
  logic [7:0]  im_q;
  logic        exl_q, ie_q;
  logic        bd_q, ti_q;
  logic [1:0]  ip_sw_q;
  logic [4:0]  exccode_q;
  logic [5:0]  ip_hw_q;
  logic        phase_q;
  logic        flush_q;
  logic [31:0] flush_pc_q;

  logic        div_tick, mtc0_en, count_wr, compare_wr, timer_match;
  logic [7:0]  ip;
  logic [5:0]  int_ext;

  // Unimplemented interrupt lines widen to zero, so IP bits above HW_INT tie off.
  assign int_ext = 6'(int_i);

  assign div_tick    = (COUNT_DIV == 1) ? 1'b1 : phase_q;
  assign mtc0_en     = we_i & ~exc_valid_i & ~eret_i;
  assign count_wr    = mtc0_en && (waddr_i == REG_COUNT);
  assign compare_wr  = mtc0_en && (waddr_i == REG_COMPARE);
  assign timer_match = div_tick & ~count_wr & (count_q == compare_q);

  assign ip         = {ti_q | ip_hw_q[5], ip_hw_q[4:0], ip_sw_q};
  assign status_o   = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause_o    = {bd_q, ti_q, 14'd0, ip, 1'b0, exccode_q, 2'b00};
  assign epc_o      = epc_q;
  assign int_req_o  = ie_q & ~exl_q & (|(ip & im_q));
  assign flush_o    = flush_q;
  assign flush_pc_o = flush_pc_q;

  always_comb begin
    rdata_o = 32'd0;
    case (raddr_i)
      REG_BADVADDR: rdata_o = badva_q;
      REG_COUNT:    rdata_o = count_q;
      REG_COMPARE:  rdata_o = compare_q;
      REG_STATUS:   rdata_o = status_o;
      REG_CAUSE:    rdata_o = cause_o;
      REG_EPC:      rdata_o = epc_q;
      REG_PRID:     rdata_o = PRID_VAL;
      REG_CONFIG:   rdata_o = CONFIG_VAL;
      default:      rdata_o = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      epc_q      <= 32'd0;
      badva_q    <= 32'd0;
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_sw_q    <= 2'd0;
      exccode_q  <= 5'd0;
      ip_hw_q    <= 6'd0;
      phase_q    <= 1'b0;
      flush_q    <= 1'b0;
      flush_pc_q <= 32'd0;
    end else begin
      ip_hw_q <= int_ext;

      // The timer runs regardless of which exception/ERET/MTC0 action wins.
      if (count_wr) begin
        count_q <= wdata_i;
        phase_q <= 1'b0;
      end else begin
        if (div_tick) count_q <= count_q + 32'd1;
        phase_q <= (COUNT_DIV == 1) ? 1'b0 : ~phase_q;
      end

      if (compare_wr) begin
        compare_q <= wdata_i;
        ti_q      <= 1'b0;
      end else if (timer_match) begin
        ti_q <= 1'b1;
      end

      flush_q <= 1'b0;
      if (exc_valid_i) begin
        exccode_q  <= exc_code_i;
        exl_q      <= 1'b1;
        if (!exl_q) begin
          epc_q <= exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
          bd_q  <= exc_bd_i;
        end
        if (exc_code_i == 5'd4 || exc_code_i == 5'd5) badva_q <= exc_badva_i;
        flush_q    <= 1'b1;
        flush_pc_q <= EXC_VEC;
      end else if (eret_i) begin
        exl_q      <= 1'b0;
        flush_q    <= 1'b1;
        flush_pc_q <= epc_q;
      end else if (mtc0_en) begin
        case (waddr_i)
          REG_STATUS: begin
            im_q  <= wdata_i[15:8];
            exl_q <= wdata_i[1];
            ie_q  <= wdata_i[0];
          end
          REG_CAUSE: ip_sw_q <= wdata_i[9:8];
          REG_EPC:   epc_q   <= wdata_i;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Scoreboard bench for cp0_ctrl: a default build plus a narrow HW_INT=2,
// COUNT_DIV=1 build, with directed vectors and hand-computed expectations.
module tb_cp0_ctrl;

  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;

  localparam int S_RDATA = 0, S_STATUS = 1, S_CAUSE = 2, S_EPC = 3, S_INTREQ = 4,
                 S_FLUSH = 5, S_NCAUSE = 6, S_NINTREQ = 7, S_NRDATA = 8,
                 S_NSTATUS = 9, S_NFLUSH = 10, S_NFLUSHPC = 11, S_NEPC = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic        we;
  logic [4:0]  waddr, raddr;
  logic [31:0] wdata, rdata;
  logic        exc_valid, exc_bd, eret;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_badva;
  logic        int_req, flush;
  logic [31:0] epc, status, cause, flush_pc;

  logic [1:0]  n_int;
  logic        n_we;
  logic [4:0]  n_waddr, n_raddr;
  logic [31:0] n_wdata, n_rdata;
  logic        n_int_req, n_flush;
  logic [31:0] n_epc, n_status, n_cause, n_flush_pc;

  typedef struct { string name; int sel; logic [31:0] exp; } chk_t;
  typedef struct { logic [31:0] pc; int cycle; } flush_t;

  chk_t   chk_q[$];
  flush_t flush_q[$];
  logic   chk_req = 1'b0;
  int     cyc = 0;
  int     num_checks = 0;
  int     num_fail = 0;
  chk_t   mon_e;
  flush_t mon_f;
  logic [31:0] mon_act;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cp0_ctrl dut (
    .clk(clk), .rst(rst), .int_i(int_i), .we_i(we), .waddr_i(waddr),
    .wdata_i(wdata), .raddr_i(raddr), .rdata_o(rdata),
    .exc_valid_i(exc_valid), .exc_code_i(exc_code), .exc_pc_i(exc_pc),
    .exc_bd_i(exc_bd), .exc_badva_i(exc_badva), .eret_i(eret),
    .int_req_o(int_req), .epc_o(epc), .status_o(status), .cause_o(cause),
    .flush_o(flush), .flush_pc_o(flush_pc)
  );

  cp0_ctrl #(.HW_INT(2), .COUNT_DIV(1)) dut_n (
    .clk(clk), .rst(rst), .int_i(n_int), .we_i(n_we), .waddr_i(n_waddr),
    .wdata_i(n_wdata), .raddr_i(n_raddr), .rdata_o(n_rdata),
    .exc_valid_i(1'b0), .exc_code_i(5'd0), .exc_pc_i(32'd0),
    .exc_bd_i(1'b0), .exc_badva_i(32'd0), .eret_i(1'b0),
    .int_req_o(n_int_req), .epc_o(n_epc), .status_o(n_status), .cause_o(n_cause),
    .flush_o(n_flush), .flush_pc_o(n_flush_pc)
  );

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      S_RDATA:    return rdata;
      S_STATUS:   return status;
      S_CAUSE:    return cause;
      S_EPC:      return epc;
      S_INTREQ:   return {31'd0, int_req};
      S_FLUSH:    return {31'd0, flush};
      S_NCAUSE:   return n_cause;
      S_NINTREQ:  return {31'd0, n_int_req};
      S_NRDATA:   return n_rdata;
      S_NSTATUS:  return n_status;
      S_NFLUSH:   return {31'd0, n_flush};
      S_NFLUSHPC: return n_flush_pc;
      default:    return n_epc;
    endcase
  endfunction

  // Monitor: flushes are matched against the expected-redirect queue, and
  // queued register expectations are compared whenever a sample is requested.
  always @(negedge clk) begin
    if (flush) begin
      num_checks++;
      if (flush_q.size() == 0) begin
        num_fail++;
        $display("[TB] FAIL flush_unexpected: flush_o=1 flush_pc_o=%h, required flush_o=0", flush_pc);
      end else begin
        mon_f = flush_q.pop_front();
        if (flush_pc !== mon_f.pc || cyc != mon_f.cycle) begin
          num_fail++;
          $display("[TB] FAIL flush_pc: got pc=%h cycle=%0d, required pc=%h cycle=%0d",
                   flush_pc, cyc, mon_f.pc, mon_f.cycle);
        end
      end
    end
    if (chk_req) begin
      while (chk_q.size() > 0) begin
        mon_e = chk_q.pop_front();
        mon_act = probe(mon_e.sel);
        num_checks++;
        if (mon_act !== mon_e.exp) begin
          num_fail++;
          $display("[TB] FAIL %s: got %h, required %h", mon_e.name, mon_act, mon_e.exp);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sample();
    chk_req = 1'b1;
    @(negedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic checkOutput(input string nm, input int sel, input logic [31:0] exp);
    chk_q.push_back('{nm, sel, exp});
  endtask

  task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                               input logic exc, input logic [4:0] code, input logic [31:0] pc,
                               input logic bd, input logic [31:0] bva,
                               input logic er, input logic [31:0] er_pc);
    we = w; waddr = wa; wdata = wd;
    exc_valid = exc; exc_code = code; exc_pc = pc; exc_bd = bd; exc_badva = bva;
    eret = er;
    if (exc) flush_q.push_back('{EXC_VEC, cyc + 1});
    else if (er) flush_q.push_back('{er_pc, cyc + 1});
    tick(1);
    we = 1'b0; exc_valid = 1'b0; eret = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    applyStimulus(1'b1, a, d, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic nMtc0(input logic [4:0] a, input logic [31:0] d);
    n_we = 1'b1; n_waddr = a; n_wdata = d;
    tick(1);
    n_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; int_i = 6'd0; we = 1'b0; waddr = 5'd0; wdata = 32'd0; raddr = 5'd0;
    exc_valid = 1'b0; exc_code = 5'd0; exc_pc = 32'd0; exc_bd = 1'b0; exc_badva = 32'd0;
    eret = 1'b0;
    n_int = 2'b00; n_we = 1'b0; n_waddr = 5'd0; n_wdata = 32'd0; n_raddr = 5'd0;
    tick(3);
    rst = 1'b0;

    raddr = 5'd15;
    checkOutput("rst_status", S_STATUS, 32'h0040_0000);
    checkOutput("rst_cause", S_CAUSE, 32'h0);
    checkOutput("rst_epc", S_EPC, 32'h0);
    checkOutput("rst_intreq", S_INTREQ, 32'h0);
    checkOutput("rst_flush", S_FLUSH, 32'h0);
    checkOutput("prid", S_RDATA, 32'h0000_4220);
    checkOutput("n_rst_cause", S_NCAUSE, 32'h0);
    sample();

    // Both Compare writes land on the first timer match after reset (0==0).
    nMtc0(5'd11, 32'h8000_0000);
    mtc0(5'd11, 32'hFFFF_0000);
    checkOutput("ti_clear_wins", S_CAUSE, 32'h0);
    checkOutput("n_ti_clear_wins", S_NCAUSE, 32'h0);
    sample();

    mtc0(5'd12, 32'hFFFF_FFFF);
    checkOutput("status_mask", S_STATUS, 32'h0040_FF03);
    checkOutput("intreq_exl_blocks", S_INTREQ, 32'h0);
    sample();
    mtc0(5'd12, 32'h0);
    mtc0(5'd13, 32'hFFFF_FFFF);
    checkOutput("cause_mask", S_CAUSE, 32'h0000_0300);
    sample();
    mtc0(5'd12, 32'h0000_0101);
    checkOutput("status_ie_im0", S_STATUS, 32'h0040_0101);
    checkOutput("intreq_sw", S_INTREQ, 32'h1);
    sample();
    mtc0(5'd13, 32'h0);
    checkOutput("cause_sw_clr", S_CAUSE, 32'h0);
    checkOutput("intreq_sw_clr", S_INTREQ, 32'h0);
    sample();

    mtc0(5'd15, 32'hFFFF_FFFF);
    mtc0(5'd16, 32'h0);
    mtc0(5'd8, 32'h1234_5678);
    raddr = 5'd15; checkOutput("prid_ro", S_RDATA, 32'h0000_4220); sample();
    raddr = 5'd16; checkOutput("config_ro", S_RDATA, 32'h8000_0000); sample();
    raddr = 5'd8;  checkOutput("badva_ro", S_RDATA, 32'h0); sample();
    raddr = 5'd31; checkOutput("unmapped31", S_RDATA, 32'h0); sample();
    raddr = 5'd10; checkOutput("unmapped10", S_RDATA, 32'h0); sample();

    mtc0(5'd14, 32'h0000_BEEF);
    raddr = 5'd14;
    checkOutput("epc_rd", S_RDATA, 32'h0000_BEEF);
    checkOutput("epc_o", S_EPC, 32'h0000_BEEF);
    sample();
    tick(1);
    we = 1'b1; waddr = 5'd14; wdata = 32'h0000_1111;
    checkOutput("no_bypass", S_RDATA, 32'h0000_BEEF);
    sample();
    tick(1);
    we = 1'b0;
    checkOutput("epc_after_wr", S_RDATA, 32'h0000_1111);
    sample();

    int_i = 6'b100001;
    tick(1);
    checkOutput("cause_hwint", S_CAUSE, 32'h0000_8400);
    checkOutput("intreq_masked", S_INTREQ, 32'h0);
    sample();
    mtc0(5'd12, 32'h0000_8001);
    checkOutput("intreq_hw5", S_INTREQ, 32'h1);
    sample();
    int_i = 6'd0;
    tick(1);
    checkOutput("cause_hw_clr", S_CAUSE, 32'h0);
    checkOutput("intreq_hw_clr", S_INTREQ, 32'h0);
    sample();

    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    tick(11);
    raddr = 5'd9;
    checkOutput("count_div2", S_RDATA, 32'd5);
    checkOutput("ti_before", S_CAUSE, 32'h0);
    checkOutput("intreq_before_ti", S_INTREQ, 32'h0);
    sample();
    tick(1);
    checkOutput("count_match", S_RDATA, 32'd6);
    checkOutput("ti_set", S_CAUSE, 32'h4000_8000);
    checkOutput("intreq_timer", S_INTREQ, 32'h1);
    sample();
    mtc0(5'd11, 32'hFFFF_0000);
    raddr = 5'd11;
    checkOutput("ti_cleared", S_CAUSE, 32'h0);
    checkOutput("intreq_ti_clr", S_INTREQ, 32'h0);
    checkOutput("compare_rd", S_RDATA, 32'hFFFF_0000);
    sample();

    n_int = 2'b10;
    nMtc0(5'd12, 32'h0000_0801);
    checkOutput("n_cause_ip3", S_NCAUSE, 32'h0000_0800);
    checkOutput("n_intreq", S_NINTREQ, 32'h1);
    checkOutput("n_status", S_NSTATUS, 32'h0040_0801);
    checkOutput("n_flush", S_NFLUSH, 32'h0);
    checkOutput("n_flush_pc", S_NFLUSHPC, 32'h0);
    checkOutput("n_epc", S_NEPC, 32'h0);
    sample();
    nMtc0(5'd9, 32'hFFFF_FFFF);
    n_raddr = 5'd9;
    checkOutput("n_count_max", S_NRDATA, 32'hFFFF_FFFF);
    sample();
    checkOutput("n_count_wrap", S_NRDATA, 32'h0);
    sample();

    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h8000_0104, 1'b1, 32'hAAAA_AAAA, 1'b0, 32'd0);
    raddr = 5'd8;
    checkOutput("exc_epc_bd", S_EPC, 32'h8000_0100);
    checkOutput("exc_cause", S_CAUSE, 32'h8000_0020);
    checkOutput("exc_status", S_STATUS, 32'h0040_8003);
    checkOutput("exc_intreq", S_INTREQ, 32'h0);
    checkOutput("exc_badva_kept", S_RDATA, 32'h0);
    sample();
    checkOutput("flush_one_cycle", S_FLUSH, 32'h0);
    sample();

    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h0000_1234, 1'b0, 32'hCAFE_0000, 1'b0, 32'd0);
    checkOutput("nested_epc", S_EPC, 32'h8000_0100);
    checkOutput("nested_cause", S_CAUSE, 32'h8000_0010);
    checkOutput("nested_badva", S_RDATA, 32'hCAFE_0000);
    sample();

    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h8000_0100);
    checkOutput("eret_status", S_STATUS, 32'h0040_8001);
    checkOutput("eret_epc", S_EPC, 32'h8000_0100);
    sample();

    applyStimulus(1'b1, 5'd14, 32'h0000_DEAD, 1'b1, 5'd12, 32'h8000_2000, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("exc_over_mtc0_epc", S_EPC, 32'h8000_2000);
    checkOutput("exc_over_mtc0_cause", S_CAUSE, 32'h0000_0030);
    checkOutput("exc_over_mtc0_status", S_STATUS, 32'h0040_8003);
    sample();

    applyStimulus(1'b1, 5'd12, 32'h0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h8000_2000);
    checkOutput("eret_over_mtc0", S_STATUS, 32'h0040_8001);
    checkOutput("eret2_epc", S_EPC, 32'h8000_2000);
    sample();

    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_0040, 1'b0, 32'h1111_2222, 1'b1, 32'd0);
    checkOutput("exc_over_eret_epc", S_EPC, 32'h0000_0040);
    checkOutput("exc_over_eret_cause", S_CAUSE, 32'h0000_0014);
    checkOutput("exc_over_eret_status", S_STATUS, 32'h0040_8003);
    checkOutput("exc_badva_code5", S_RDATA, 32'h1111_2222);
    sample();

    // Reset lands while a flush is visible; the commands in the reset cycle are dropped.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h0000_0050, 1'b0, 32'd0, 1'b0, 32'd0);
    rst = 1'b1;
    exc_valid = 1'b1; exc_code = 5'd4; exc_badva = 32'hFFFF_FFFF; eret = 1'b1;
    we = 1'b1; waddr = 5'd12; wdata = 32'hFFFF_FFFF;
    tick(1);
    rst = 1'b0; exc_valid = 1'b0; eret = 1'b0; we = 1'b0;
    raddr = 5'd9;
    checkOutput("mid_rst_flush", S_FLUSH, 32'h0);
    checkOutput("mid_rst_status", S_STATUS, 32'h0040_0000);
    checkOutput("mid_rst_cause", S_CAUSE, 32'h0);
    checkOutput("mid_rst_epc", S_EPC, 32'h0);
    checkOutput("mid_rst_count", S_RDATA, 32'h0);
    sample();
    raddr = 5'd8;  checkOutput("mid_rst_badva", S_RDATA, 32'h0); sample();
    raddr = 5'd11; checkOutput("mid_rst_compare", S_RDATA, 32'h0); sample();

    tick(2);
    num_checks++;
    if (flush_q.size() != 0) begin
      num_fail++;
      $display("[TB] FAIL flush_missing: %0d redirects outstanding, required 0", flush_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
